// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
package mips_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT = 4;

    typedef enum logic [0:0] {
        StBoot,
        StRun
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, boot FSM and debug counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      inst_in,
    output logic [31:0]      pc_out,
    output logic [31:0]      if_id_inst,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] bubble_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         fetch_inc, bubble_inc;
    logic [31:0]  pc_next_seq;

    assign pc_next_seq = pc_q + PC_STEP;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        fetch_inc  = 1'b0;
        bubble_inc = 1'b0;
        unique case (state_q)
            // Memory settling cycle: control inputs are ignored and the bubble is not counted.
            StBoot: begin
                state_d = StRun;
                pc_d    = RESET_PC;
                inst_d  = NOP_INST;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
            StRun: begin
                if (branch_taken) begin
                    pc_d       = branch_target;
                    inst_d     = NOP_INST;
                    pc4_d      = '0;
                    valid_d    = 1'b0;
                    bubble_inc = 1'b1;
                end else begin
                    if (!stall) begin
                        pc_d = pc_next_seq;
                    end
                    if (flush) begin
                        inst_d     = NOP_INST;
                        pc4_d      = '0;
                        valid_d    = 1'b0;
                        bubble_inc = 1'b1;
                    end else if (!stall) begin
                        inst_d    = inst_in;
                        pc4_d     = pc_next_seq;
                        valid_d   = 1'b1;
                        fetch_inc = 1'b1;
                    end
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_fetch_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (fetch_inc),
        .count(fetch_count)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (bubble_inc),
        .count(bubble_count)
    );

    assign pc_out      = pc_q;
    assign if_id_inst  = inst_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter, drives the instruction memory address, and captures the returned word into the IF/ID pipeline register. It handles stall, flush and taken-branch redirect from the later stages. It also keeps fetch and bubble counters for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential PC increment; instruction memory is byte-addressed on word boundaries.
CNT_W, 16, width of the fetch and bubble counters.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID contents
flush  input  1  control: replace IF/ID with a bubble at the next edge
branch_taken  input  1  EX/ID: branch resolved taken this cycle
branch_target  input  32  redirect address, used as-is
inst_in  input  32  instruction word from instruction memory (combinational read of pc_out)
pc_out  output  32  current PC, addressing instruction memory
if_id_inst  output  32  registered instruction
if_id_pc4  output  32  registered PC+PC_STEP of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
fetch_count  output  CNT_W  valid instructions captured into IF/ID
bubble_count  output  CNT_W  bubbles inserted into IF/ID

Behaviour:
- Reset (rst=1 at an edge) wins over everything. Resulting values:
  - pc_out = RESET_PC
  - if_id_inst = 0, if_id_pc4 = 0, if_id_valid = 0
  - counters = 0
  - FSM enters BOOT
- A reset asserted mid-operation discards any pending redirect or stall.
- FSM has 2 states, BOOT and RUN.
  - BOOT lasts exactly one cycle after reset deasserts, giving the memory one settling cycle.
  - In BOOT, PC holds at RESET_PC and IF/ID loads a bubble. bubble_count does not increment.
  - BOOT always moves to RUN; stall, flush and branch are ignored in BOOT.
- RUN: per-edge priority is branch_taken > stall > normal. flush is evaluated independently for IF/ID only.
  - branch_taken=1: pc_out <= branch_target. IF/ID <= bubble (the wrong-path inst_in is squashed), regardless of stall. bubble_count++.
  - else stall=1: PC holds. If flush=1, IF/ID <= bubble and bubble_count++; otherwise IF/ID holds. Neither counter changes when IF/ID holds.
  - else normal: pc_out <= pc_out + PC_STEP.
    - If flush=1, IF/ID <= bubble and bubble_count++.
    - Otherwise if_id_inst <= inst_in, if_id_pc4 <= pc_out + PC_STEP, if_id_valid <= 1, fetch_count++.
- Bubble encoding: if_id_inst = 32'h0000_0000 (sll $0 NOP), if_id_pc4 = 0, if_id_valid = 0.
- Latency: the instruction at address A appears on if_id_inst one edge after pc_out = A. A redirect costs exactly one bubble.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. No trap is raised.
- Counters saturate at all-ones and do not wrap.
- pc_out is a register output and is never combinational from inputs.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INST = 32'h0
  - fetch FSM state typedef {BOOT, RUN}
  - PC_STEP default
- One natural sub-module, sat_counter (CNT_W, inc, rst), instantiated twice for fetch_count and bubble_count.
- The PC register and IF/ID register stay inline.

Test Plan:
- Reset/boot, RESET_PC=4, stub memory {4:0x00641020, 8:0x00640822, 12:0x8CC50000}: after rst falls, pc_out=4 for 2 cycles. Then if_id_inst=0x00641020 with if_id_pc4=8, then 0x00640822 with pc4=12. fetch_count=2, bubble_count=0.
- Stall for 3 cycles at pc_out=8: pc_out stays 8 and if_id_inst stays 0x00641020. On release, pc_out goes 8->12 and if_id_inst=0x00640822.
- branch_taken with target=4 while pc_out=16: next edge pc_out=4, if_id_valid=0, bubble_count+1. The edge after, if_id_inst=0x00641020.
- branch_taken and stall asserted together: branch wins. pc_out=branch_target and IF/ID is a bubble.
- stall+flush together at pc_out=12: pc_out holds at 12, if_id_valid=0, bubble_count+1. Then assert rst mid-run: next edge pc_out=RESET_PC and all outputs zero.
- Force pc_out near the top (branch_target=32'hFFFF_FFFC), then run normally: pc_out wraps to 0. Preload fetch_count near 0xFFFF (bench force): it saturates at 0xFFFF.
